spi_flash_resp: RTL and testbench

//  Synthesizable SPI flash responder (target side, mode 0), oversampled on the system clock.
//  It emulates the boot flash seen by the soc SPI master. It lets a second board or a sim bench
//  act as the flash. Commands supported: READ 0x03, JEDEC ID 0x9F, optional FAST READ 0x0B.

---
 rtl/spi_flash_resp.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_flash_resp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash responder (READ 0x03, JEDEC ID 0x9F), oversampled on clk.
// Define SPI_RESP_FAST_READ_EN to also accept FAST READ 0x0B with 8 dummy clocks.
module spi_flash_resp #(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int unsigned MEM_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_ssn,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int unsigned LatW = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StId,
`ifdef SPI_RESP_FAST_READ_EN
    StDummy,
`endif
    StIgnore
  } state_e;

  state_e            state;
  logic [1:0]        sck_s;
  logic [1:0]        ssn_s;
  logic [1:0]        mosi_s;
  logic              sck_prev;
  logic [4:0]        bit_cnt;
  logic [6:0]        cmd_sh;
  logic [22:0]       addr_sh;
  logic [6:0]        tx;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hold;
  logic              hold_vld;
  logic              pending;
  logic [LatW-1:0]   lat_cnt;
  logic [1:0]        id_idx;
`ifdef SPI_RESP_FAST_READ_EN
  logic              fast;
`endif

  logic        sck_rise;
  logic        sck_fall;
  logic        mosi_bit;
  logic [7:0]  cmd_full;
  logic [23:0] addr_full;
  logic [7:0]  fetch_byte;
  logic [7:0]  id_byte;
  logic [7:0]  tx_byte;

  assign sck_rise  = sck_s[1] & ~sck_prev;
  assign sck_fall  = ~sck_s[1] & sck_prev;
  assign mosi_bit  = mosi_s[1];
  assign cmd_full  = {cmd_sh, mosi_bit};
  assign addr_full = {addr_sh, mosi_bit};

  // A byte landing on the very cycle of the boundary still counts as on time.
  always_comb begin
    fetch_byte = 8'hFF;
    if (pending && mem_ack) begin
      fetch_byte = mem_rdata;
    end else if (hold_vld) begin
      fetch_byte = hold;
    end
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
    tx_byte = (state == StId) ? id_byte : fetch_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      sck_s       <= 2'b00;
      ssn_s       <= 2'b11;
      mosi_s      <= 2'b00;
      sck_prev    <= 1'b0;
      bit_cnt     <= '0;
      cmd_sh      <= '0;
      addr_sh     <= '0;
      tx          <= '0;
      addr        <= '0;
      hold        <= '0;
      hold_vld    <= 1'b0;
      pending     <= 1'b0;
      lat_cnt     <= '0;
      id_idx      <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
      fast        <= 1'b0;
`endif
    end else begin
      sck_s    <= {sck_s[0], spi_sck};
      ssn_s    <= {ssn_s[0], spi_ssn};
      mosi_s   <= {mosi_s[0], spi_mosi};
      sck_prev <= sck_s[1];
      busy     <= ~ssn_s[1];
      mem_req  <= 1'b0;

      // Outstanding fetch: capture the ack even after an abort; give up after MEM_LAT.
      if (pending) begin
        if (mem_ack) begin
          pending  <= 1'b0;
          hold     <= mem_rdata;
          hold_vld <= 1'b1;
        end else if (lat_cnt == LatW'(MEM_LAT)) begin
          pending <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end

      if (ssn_s[1]) begin
        state       <= StIdle;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        bit_cnt     <= '0;
        tx          <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            state   <= StCmd;
            bit_cnt <= '0;
          end
          StCmd: begin
            if (sck_rise) begin
              cmd_sh <= cmd_full[6:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                case (cmd_full)
                  8'h03: state <= StAddr;
                  8'h9F: begin
                    state       <= StId;
                    id_idx      <= '0;
                    spi_miso_oe <= 1'b1;
                  end
`ifdef SPI_RESP_FAST_READ_EN
                  8'h0B: state <= StAddr;
`endif
                  default: state <= StIgnore;
                endcase
`ifdef SPI_RESP_FAST_READ_EN
                fast <= (cmd_full == 8'h0B);
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          StAddr: begin
            if (sck_rise) begin
              addr_sh <= addr_full[22:0];
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                addr     <= addr_full[ADDR_W-1:0];
                mem_addr <= addr_full[ADDR_W-1:0];
                mem_req  <= 1'b1;
                pending  <= 1'b1;
                lat_cnt  <= '0;
                hold_vld <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
                if (fast) begin
                  state <= StDummy;
                end else begin
                  state       <= StData;
                  spi_miso_oe <= 1'b1;
                end
`else
                state       <= StData;
                spi_miso_oe <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
`ifdef SPI_RESP_FAST_READ_EN
          StDummy: begin
            if (sck_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt     <= '0;
                state       <= StData;
                spi_miso_oe <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
`endif
          StData, StId: begin
            if (sck_fall) begin
              bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 1'b1;
              if (bit_cnt == 5'd0) begin
                spi_miso <= tx_byte[7];
                tx       <= tx_byte[6:0];
                if (state == StId) begin
                  id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 1'b1;
                end else begin
                  // Prefetch the next byte a full byte time ahead; a late fetch is dropped.
                  hold_vld <= 1'b0;
                  addr     <= addr + ADDR_W'(1);
                  mem_addr <= addr + ADDR_W'(1);
                  mem_req  <= 1'b1;
                  pending  <= 1'b1;
                  lat_cnt  <= '0;
                end
              end else begin
                spi_miso <= tx[6];
                tx       <= {tx[5:0], 1'b0};
              end
            end
          end
          StIgnore: begin
            spi_miso_oe <= 1'b0;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: READ, JEDEC ID, wrap, ignore, abort, reset, fast read.
module tb_spi_flash_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_ssn;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        busy;

  logic        ack_en;
  logic        d1 = 1'b0;
  logic [7:0]  a1 = 8'h00;
  int          req_cnt = 0;
  int          oe_cnt = 0;
  logic [23:0] req_log [0:255];

  int checks = 0;
  int errors = 0;

  spi_flash_resp dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_ssn    (spi_ssn),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Memory returns addr[7:0], acked two cycles after the request.
  always @(posedge clk) begin
    d1        <= mem_req & ack_en;
    a1        <= mem_addr[7:0];
    mem_ack   <= d1;
    mem_rdata <= a1;
    if (mem_req) begin
      req_log[req_cnt[7:0]] <= mem_addr;
      req_cnt <= req_cnt + 1;
    end
    if (spi_miso_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_sck  = 1'b0;
    spi_mosi = b;
    #80;
    r       = spi_miso;
    spi_sck = 1'b1;
    #80;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], t);
      r[i] = t;
    end
  endtask

  task automatic start_xfer();
    @(negedge clk);
    spi_ssn = 1'b0;
    #80;
  endtask

  task automatic stop_xfer();
    spi_ssn = 1'b1;
    #100;
    spi_sck = 1'b0;
    #200;
  endtask

  task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] r;
    spi_byte(cmd, r);
    spi_byte(a[23:16], r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       t;
    logic [3:0] nib;
    int         base;
    int         oe_base;

    rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    spi_ssn  = 1'b1;
    ack_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #100;

    // 1: READ 0x000100, three bytes
    base = req_cnt;
    start_xfer();
    check("t1_busy", busy, 1);
    send_cmd_addr(8'h03, 24'h000100);
    spi_byte(8'h00, r); check("t1_b0", r, 8'h00);
    check("t1_oe", spi_miso_oe, 1);
    spi_byte(8'h00, r); check("t1_b1", r, 8'h01);
    spi_byte(8'h00, r); check("t1_b2", r, 8'h02);
    stop_xfer();
    check("t1_oe_off", spi_miso_oe, 0);
    check("t1_busy_off", busy, 0);
    check("t1_nreq", req_cnt - base, 4);
    check("t1_a0", req_log[base], 24'h000100);
    check("t1_a1", req_log[base+1], 24'h000101);
    check("t1_a2", req_log[base+2], 24'h000102);
    check("t1_a3", req_log[base+3], 24'h000103);

    // 2: JEDEC ID, six bytes
    base = req_cnt;
    start_xfer();
    spi_byte(8'h9F, r);
    spi_byte(8'h00, r); check("t2_id0", r, 8'hEF);
    spi_byte(8'h00, r); check("t2_id1", r, 8'h40);
    spi_byte(8'h00, r); check("t2_id2", r, 8'h16);
    spi_byte(8'h00, r); check("t2_id3", r, 8'hEF);
    spi_byte(8'h00, r); check("t2_id4", r, 8'h40);
    spi_byte(8'h00, r); check("t2_id5", r, 8'h16);
    stop_xfer();
    check("t2_noreq", req_cnt - base, 0);

    // 3: address wrap
    base = req_cnt;
    start_xfer();
    send_cmd_addr(8'h03, 24'hFFFFFE);
    spi_byte(8'h00, r); check("t3_b0", r, 8'hFE);
    spi_byte(8'h00, r); check("t3_b1", r, 8'hFF);
    spi_byte(8'h00, r); check("t3_b2", r, 8'h00);
    stop_xfer();
    check("t3_a0", req_log[base], 24'hFFFFFE);
    check("t3_a1", req_log[base+1], 24'hFFFFFF);
    check("t3_a2", req_log[base+2], 24'h000000);

    // 4: unknown command then JEDEC
    base    = req_cnt;
    oe_base = oe_cnt;
    start_xfer();
    spi_byte(8'h05, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    stop_xfer();
    check("t4_no_oe", oe_cnt - oe_base, 0);
    check("t4_noreq", req_cnt - base, 0);
    start_xfer();
    spi_byte(8'h9F, r);
    spi_byte(8'h00, r); check("t4_id0", r, 8'hEF);
    spi_byte(8'h00, r); check("t4_id1", r, 8'h40);
    stop_xfer();

    // 5: abort mid byte 2, then a fresh READ
    start_xfer();
    send_cmd_addr(8'h03, 24'h000020);
    spi_byte(8'h00, r); check("t5_b0", r, 8'h20);
    for (int i = 3; i >= 0; i--) begin
      spi_bit(1'b0, t);
      nib[i] = t;
    end
    check("t5_nib", nib, 4'h2);
    @(negedge clk);
    spi_ssn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_oe_off", spi_miso_oe, 0);
    check("t5_miso0", spi_miso, 0);
    #100;
    spi_sck = 1'b0;
    #200;
    start_xfer();
    send_cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, r); check("t5_new", r, 8'h10);
    stop_xfer();

    // 6a: withheld ack yields 0xFF
    base   = req_cnt;
    ack_en = 1'b0;
    start_xfer();
    send_cmd_addr(8'h03, 24'h000005);
    spi_byte(8'h00, r); check("t6_ff0", r, 8'hFF);
    spi_byte(8'h00, r); check("t6_ff1", r, 8'hFF);
    stop_xfer();
    ack_en = 1'b1;
    check("t6_nreq", req_cnt - base, 3);
    check("t6_lastaddr", mem_addr, 24'h000007);

    // 6b: reset in the middle of the address phase
    start_xfer();
    spi_byte(8'h03, r);
    for (int i = 0; i < 12; i++) spi_bit(1'b1, t);
    @(negedge clk);
    rst     = 1'b1;
    spi_ssn = 1'b1;
    spi_sck = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_oe", spi_miso_oe, 0);
    check("t6_rst_miso", spi_miso, 0);
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = req_cnt;
    #400;
    check("t6_rst_noreq", req_cnt - base, 0);
    start_xfer();
    spi_byte(8'h9F, r);
    spi_byte(8'h00, r); check("t6_post_id", r, 8'hEF);
    stop_xfer();

    // 6c: FAST READ with 8 dummy clocks
    base    = req_cnt;
    oe_base = oe_cnt;
    start_xfer();
    send_cmd_addr(8'h0B, 24'h000040);
    spi_byte(8'h00, r);
`ifdef SPI_RESP_FAST_READ_EN
    spi_byte(8'h00, r); check("t6_fr0", r, 8'h40);
    spi_byte(8'h00, r); check("t6_fr1", r, 8'h41);
    stop_xfer();
    check("t6_fr_a0", req_log[base], 24'h000040);
`else
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    stop_xfer();
    check("t6_fr_no_oe", oe_cnt - oe_base, 0);
    check("t6_fr_noreq", req_cnt - base, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
